// File: rtl/chr_sdram_loader.sv
// chr_sdram_loader: writes a host byte stream (the PPU CHR image) into
// consecutive SDRAM byte addresses through the controller command port, then
// raises init_sdram_data so the fetch bridge may start reading.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   load_start       one-cycle pulse, (re)starts a load from BASE_ADDR
//   rx_data/rx_valid incoming stream byte, no back-pressure
//   ram_addr         SDRAM write address (BASE_ADDR + byte_count)
//   ram_data_in      SDRAM write data
//   ram_rw           write strobe level, always 1
//   in_valid         command request; accepted on any edge with busy=0
//   busy             controller cannot take a command this cycle
//   init_sdram_data  image fully written
//   overflow         sticky, a stream byte was dropped
//   byte_count       bytes accepted by the controller in this load
module chr_sdram_loader #(
    parameter logic [22:0] BASE_ADDR  = 23'd0,
    parameter int unsigned LOAD_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [22:0] ram_addr,
    output logic [7:0]  ram_data_in,
    output logic        ram_rw,
    output logic        in_valid,
    input  logic        busy,
    output logic        init_sdram_data,
    output logic        overflow,
    output logic [22:0] byte_count
);

    localparam int unsigned ADDR_W = 23;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]        state, state_d;
    logic [ADDR_W-1:0] addr_d, count_d, count_inc;
    logic [7:0]        data_d, skid_data, skid_data_d;
    logic              skid_full, skid_full_d;
    logic              in_valid_d, init_d, overflow_d;
    logic              accept;

    assign count_inc = byte_count + ADDR_W'(1);
    assign accept    = (state == WRITE) && in_valid && !busy;

    // Next-state and next-output computation
    always_comb begin
        state_d     = state;
        addr_d      = ram_addr;
        data_d      = ram_data_in;
        count_d     = byte_count;
        skid_data_d = skid_data;
        skid_full_d = skid_full;
        in_valid_d  = in_valid;
        init_d      = init_sdram_data;
        overflow_d  = overflow;

        if (load_start) begin
            // Restart wins over everything; a same-edge accept is not counted.
            state_d     = COLLECT;
            addr_d      = BASE_ADDR;
            count_d     = '0;
            skid_full_d = 1'b0;
            in_valid_d  = 1'b0;
            init_d      = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    addr_d = BASE_ADDR + byte_count;
                    if (skid_full) begin
                        data_d      = skid_data;
                        in_valid_d  = 1'b1;
                        state_d     = WRITE;
                        skid_full_d = rx_valid;
                        if (rx_valid) skid_data_d = rx_data;
                    end else if (rx_valid) begin
                        data_d     = rx_data;
                        in_valid_d = 1'b1;
                        state_d    = WRITE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        count_d    = count_inc;
                        in_valid_d = 1'b0;
                        if (count_inc == ADDR_W'(LOAD_BYTES)) begin
                            state_d     = DONE;
                            init_d      = 1'b1;
                            skid_full_d = 1'b0;
                        end else begin
                            addr_d = BASE_ADDR + count_inc;
                            if (skid_full) begin
                                data_d  = skid_data;
                                state_d = WRITE;
                            end else begin
                                state_d = COLLECT;
                            end
                            // Skid byte advanced (or slot was empty): new byte takes the slot.
                            skid_full_d = rx_valid;
                            if (rx_valid) skid_data_d = rx_data;
                        end
                    end else begin
                        // One idle cycle follows every accept; re-arm the request.
                        if (!in_valid) in_valid_d = 1'b1;
                        if (rx_valid) begin
                            if (!skid_full) begin
                                skid_full_d = 1'b1;
                                skid_data_d = rx_data;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ram_addr        <= BASE_ADDR;
            ram_data_in     <= '0;
            ram_rw          <= 1'b1;
            in_valid        <= 1'b0;
            init_sdram_data <= 1'b0;
            overflow        <= 1'b0;
            byte_count      <= '0;
            skid_full       <= 1'b0;
            skid_data       <= '0;
        end else begin
            state           <= state_d;
            ram_addr        <= addr_d;
            ram_data_in     <= data_d;
            ram_rw          <= 1'b1;
            in_valid        <= in_valid_d;
            init_sdram_data <= init_d;
            overflow        <= overflow_d;
            byte_count      <= count_d;
            skid_full       <= skid_full_d;
            skid_data       <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_chr_sdram_loader.sv
// Directed self-checking bench for chr_sdram_loader. Three instances share the
// stimulus: 0 = default (BASE 0, 8192 bytes), 1 = BASE 0x1000, 2 = LOAD_BYTES 1.
module tb_chr_sdram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;

    logic [22:0] ad [3];
    logic [7:0]  da [3];
    logic        rw [3];
    logic        iv [3];
    logic        ini [3];
    logic        ov [3];
    logic [22:0] bc [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chr_sdram_loader u_main (
        .clk(clk), .rst(rst), .load_start(load_start), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_addr(ad[0]), .ram_data_in(da[0]), .ram_rw(rw[0]), .in_valid(iv[0]), .busy(busy),
        .init_sdram_data(ini[0]), .overflow(ov[0]), .byte_count(bc[0])
    );

    chr_sdram_loader #(.BASE_ADDR(23'h1000), .LOAD_BYTES(8192)) u_base (
        .clk(clk), .rst(rst), .load_start(load_start), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_addr(ad[1]), .ram_data_in(da[1]), .ram_rw(rw[1]), .in_valid(iv[1]), .busy(busy),
        .init_sdram_data(ini[1]), .overflow(ov[1]), .byte_count(bc[1])
    );

    chr_sdram_loader #(.BASE_ADDR(23'd0), .LOAD_BYTES(1)) u_one (
        .clk(clk), .rst(rst), .load_start(load_start), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_addr(ad[2]), .ram_data_in(da[2]), .ram_rw(rw[2]), .in_valid(iv[2]), .busy(busy),
        .init_sdram_data(ini[2]), .overflow(ov[2]), .byte_count(bc[2])
    );

    task automatic pulse_load;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Present one byte for one cycle; on return the DUT has latched it.
    task automatic send_byte(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Wait for the next accepted command on instance idx and check it.
    task automatic wait_accept(input int idx, input logic [22:0] ea, input logic [7:0] ed);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (iv[idx] === 1'b1 && busy === 1'b0) begin
                found = 1;
                checks++;
                if (ad[idx] !== ea || da[idx] !== ed) begin
                    failures++;
                    $display("FAIL accept[%0d] addr=%h data=%h required addr=%h data=%h",
                             idx, ad[idx], da[idx], ea, ed);
                end
            end
            @(negedge clk);
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout[%0d] no command, required addr=%h data=%h", idx, ea, ed);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (iv[0] !== 1'b0 || ini[0] !== 1'b0 || ov[0] !== 1'b0 || bc[0] !== 23'd0) begin
            failures++;
            $display("FAIL reset_flags iv=%b init=%b ovf=%b cnt=%0d required 0 0 0 0",
                     iv[0], ini[0], ov[0], bc[0]);
        end
        checks++;
        if (ad[0] !== 23'd0 || da[0] !== 8'd0 || rw[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_bus addr=%h data=%h rw=%b required 0 0 1", ad[0], da[0], rw[0]);
        end
        checks++;
        if (ad[1] !== 23'h1000) begin
            failures++;
            $display("FAIL reset_base_addr addr=%h required 001000", ad[1]);
        end
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'hEE);  // IDLE ignores the stream
        checks++;
        if (iv[0] !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignores_rx in_valid=%b required 0", iv[0]);
        end
    endtask

    task automatic test_busy_hold;
        pulse_load();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(i));
            wait_accept(0, 23'(i), 8'(i));
        end
        busy = 1'b1;
        send_byte(8'h5A);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (iv[0] !== 1'b1 || ad[0] !== 23'd3 || da[0] !== 8'h5A || bc[0] !== 23'd3) begin
                failures++;
                $display("FAIL busy_hold cyc%0d iv=%b addr=%h data=%h cnt=%0d required 1 3 5a 3",
                         c, iv[0], ad[0], da[0], bc[0]);
            end
            @(negedge clk);
        end
        busy = 1'b0;
        @(negedge clk);
        checks++;
        if (iv[0] !== 1'b0 || bc[0] !== 23'd4) begin
            failures++;
            $display("FAIL busy_release iv=%b cnt=%0d required 0 4", iv[0], bc[0]);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (iv[0] !== 1'b0 || bc[0] !== 23'd4) begin
                failures++;
                $display("FAIL busy_single_accept iv=%b cnt=%0d required 0 4", iv[0], bc[0]);
            end
        end
    endtask

    task automatic test_skid_overflow;
        pulse_load();
        busy = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        checks++;
        if (ov[0] !== 1'b1 || iv[0] !== 1'b1 || da[0] !== 8'h11 || ad[0] !== 23'd0) begin
            failures++;
            $display("FAIL skid_drop ovf=%b iv=%b data=%h addr=%h required 1 1 11 0",
                     ov[0], iv[0], da[0], ad[0]);
        end
        repeat (7) @(negedge clk);
        busy = 1'b0;
        wait_accept(0, 23'd0, 8'h11);
        wait_accept(0, 23'd1, 8'h22);
        repeat (5) begin
            checks++;
            if (iv[0] !== 1'b0) begin
                failures++;
                $display("FAIL skid_no_third in_valid=%b required 0", iv[0]);
            end
            @(negedge clk);
        end
        checks++;
        if (bc[0] !== 23'd2 || ov[0] !== 1'b1) begin
            failures++;
            $display("FAIL skid_final cnt=%0d ovf=%b required 2 1", bc[0], ov[0]);
        end
    endtask

    task automatic test_same_edge;
        pulse_load();
        send_byte(8'h40);
        checks++;
        if (iv[1] !== 1'b1 || ad[1] !== 23'h1000 || da[1] !== 8'h40) begin
            failures++;
            $display("FAIL same_edge_first iv=%b addr=%h data=%h required 1 001000 40",
                     iv[1], ad[1], da[1]);
        end
        send_byte(8'h41);  // arrives on the accepting edge of 0x40
        wait_accept(1, 23'h1001, 8'h41);
        checks++;
        if (ov[1] !== 1'b0 || bc[1] !== 23'd2) begin
            failures++;
            $display("FAIL same_edge_nodrop ovf=%b cnt=%0d required 0 2", ov[1], bc[1]);
        end
    endtask

    task automatic test_load_start_mid;
        pulse_load();
        for (int i = 0; i < 100; i++) begin
            send_byte(8'(i + 7));
            wait_accept(0, 23'(i), 8'(i + 7));
        end
        busy = 1'b1;
        send_byte(8'h77);
        send_byte(8'h78);
        send_byte(8'h79);
        checks++;
        if (iv[0] !== 1'b1 || ad[0] !== 23'd100 || ov[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup iv=%b addr=%0d ovf=%b required 1 100 1", iv[0], ad[0], ov[0]);
        end
        busy       = 1'b0;
        load_start = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'hCC;
        @(negedge clk);
        load_start = 1'b0;
        rx_valid   = 1'b0;
        checks++;
        if (iv[0] !== 1'b0 || bc[0] !== 23'd0 || ov[0] !== 1'b0 || ad[0] !== 23'd0) begin
            failures++;
            $display("FAIL mid_restart iv=%b cnt=%0d ovf=%b addr=%h required 0 0 0 0",
                     iv[0], bc[0], ov[0], ad[0]);
        end
        @(negedge clk);
        checks++;
        if (iv[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_rx_discarded in_valid=%b required 0", iv[0]);
        end
        send_byte(8'h88);
        wait_accept(0, 23'd0, 8'h88);
        checks++;
        if (bc[0] !== 23'd1) begin
            failures++;
            $display("FAIL mid_next cnt=%0d required 1", bc[0]);
        end
    endtask

    task automatic test_load_one;
        pulse_load();
        send_byte(8'hA5);
        wait_accept(2, 23'd0, 8'hA5);
        checks++;
        if (ini[2] !== 1'b1 || bc[2] !== 23'd1 || iv[2] !== 1'b0) begin
            failures++;
            $display("FAIL one_done init=%b cnt=%0d iv=%b required 1 1 0", ini[2], bc[2], iv[2]);
        end
        send_byte(8'h5B);
        repeat (3) begin
            checks++;
            if (iv[2] !== 1'b0 || ini[2] !== 1'b1) begin
                failures++;
                $display("FAIL one_done_ignores iv=%b init=%b required 0 1", iv[2], ini[2]);
            end
            @(negedge clk);
        end
        pulse_load();
        checks++;
        if (ini[2] !== 1'b0 || bc[2] !== 23'd0) begin
            failures++;
            $display("FAIL one_restart init=%b cnt=%0d required 0 0", ini[2], bc[2]);
        end
    endtask

    task automatic test_full_load;
        pulse_load();
        for (int i = 0; i < 8192; i++) begin
            send_byte(8'(i));
            if (i == 8191) begin
                checks++;
                if (ini[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL full_early_init init=%b required 0", ini[0]);
                end
            end
            wait_accept(0, 23'(i), 8'(i));
        end
        checks++;
        if (ini[0] !== 1'b1 || ov[0] !== 1'b0 || bc[0] !== 23'd8192) begin
            failures++;
            $display("FAIL full_done init=%b ovf=%b cnt=%0d required 1 0 8192", ini[0], ov[0], bc[0]);
        end
        send_byte(8'h12);
        checks++;
        if (iv[0] !== 1'b0 || ini[0] !== 1'b1) begin
            failures++;
            $display("FAIL full_done_ignores iv=%b init=%b required 0 1", iv[0], ini[0]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        busy       = 1'b0;
        @(negedge clk);
        test_reset();
        test_busy_hold();
        test_skid_overflow();
        test_same_edge();
        test_load_start_mid();
        test_load_one();
        test_full_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
